// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, framing/break handling and a
// single-byte holding register with ready/read handshake and overrun flag.
module uart_rx #(
  parameter int unsigned CLK_HZ = 10000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned OVS    = 16
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_rdy_o,
  output logic       uart_ferr_o,
  output logic       uart_ovr_o,
  output logic       uart_busy_o
);

  localparam int unsigned INC   = BAUD * OVS;
  localparam int          ACC_W = $clog2(CLK_HZ + INC + 1);
  localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);
  localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK_HZ);
  localparam logic [3:0] MID_TICK = 4'(OVS / 2 - 1);
  localparam logic [3:0] BIT_TICK = 4'(OVS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_e;

  state_e           state_q;
  logic             meta_q;
  logic             rxs_q;
  logic             rxs_prev_q;
  logic [1:0]       fill_q;
  logic             armed_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_d;
  logic             tick;
  logic             start_det;
  logic [3:0]       tick_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       dat_q;
  logic             rdy_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             busy_q;

  // The synchronizer resets high, so its first real samples are not trusted
  // for edge detection: a start needs a genuine high level seen after reset.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      fill_q     <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      meta_q     <= uart_rx_i;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end else if (rxs_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign acc_sum   = acc_q + INC_V;
  assign tick      = (acc_sum >= CLK_V);
  assign acc_d     = tick ? (acc_sum - CLK_V) : acc_sum;
  assign start_det = (state_q == IDLE) && armed_q && rxs_prev_q && !rxs_q;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      dat_q      <= 8'd0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      acc_q  <= acc_d;
      if (uart_rd_i && rdy_q) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q    <= START;
            tick_cnt_q <= 4'd0;
            acc_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == MID_TICK) begin
              tick_cnt_q <= 4'd0;
              if (!rxs_q) begin
                state_q   <= DATA;
                bit_idx_q <= 3'd0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_q == BIT_TICK) begin
              tick_cnt_q <= 4'd0;
              shift_q    <= {rxs_q, shift_q[7:1]};
              if (bit_idx_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_q == BIT_TICK) begin
              tick_cnt_q <= 4'd0;
              if (rxs_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                // A read in the same cycle frees the holder for the new byte.
                if (!rdy_q || uart_rd_i) begin
                  dat_q <= shift_q;
                  rdy_q <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BRK;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        BRK: begin
          if (rxs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_dat_o  = dat_q;
  assign uart_rdy_o  = rdy_q;
  assign uart_ferr_o = ferr_q;
  assign uart_ovr_o  = ovr_q;
  assign uart_busy_o = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames from a fractional bit
// timer and compares deliveries against a transaction-level holding model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam real CPB = 10000000.0 / 115200.0;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] uart_dat_o;
  logic       uart_rdy_o;
  logic       uart_ferr_o;
  logic       uart_ovr_o;
  logic       uart_busy_o;

  uart_rx #(.CLK_HZ(10000000), .BAUD(115200), .OVS(16)) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .uart_rx_i  (rx),
    .uart_rd_i  (rd),
    .uart_dat_o (uart_dat_o),
    .uart_rdy_o (uart_rdy_o),
    .uart_ferr_o(uart_ferr_o),
    .uart_ovr_o (uart_ovr_o),
    .uart_busy_o(uart_busy_o)
  );

  always #50 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ferr_pulses = 0;
  int ferr_cycles = 0;
  logic ferr_prev = 1'b0;

  always @(negedge clk) begin
    if (uart_ferr_o === 1'b1) ferr_cycles++;
    if (uart_ferr_o === 1'b1 && ferr_prev !== 1'b1) ferr_pulses++;
    ferr_prev = uart_ferr_o;
  end

  // Transaction-level model of the holding register
  bit         auto_rd = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] m_dat = 8'h00;
  bit         m_rdy = 1'b0;
  bit         m_ovr = 1'b0;

  task automatic m_deliver(input logic [7:0] d);
    if (!m_rdy) begin
      m_dat = d;
      m_rdy = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic m_read();
    if (m_rdy) begin
      m_rdy = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic step_cycle();
    logic [7:0] e;
    @(negedge clk);
    rd = 1'b0;
    if (auto_rd && uart_rdy_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL auto_read: got byte %02h, expected none", uart_dat_o);
      end else begin
        e = exp_q.pop_front();
        if (uart_dat_o !== e) begin
          errors++;
          $display("FAIL auto_read: got %02h want %02h", uart_dat_o, e);
        end else begin
          $display("read byte %02h", uart_dat_o);
        end
      end
      rd = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic level);
    for (int i = 0; i < n; i++) begin
      step_cycle();
      rx = level;
    end
  endtask

  // One frame, cycle by cycle; optional read strobe and early abort.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input real skew,
                            input int rd_cycle, input int abort_cycle, output int rdy_cycle);
    real cpb;
    int  n;
    int  bp;
    bit  rdy0;
    cpb = CPB * (1.0 + skew);
    n = $rtoi(10.0 * cpb + 0.5);
    rdy_cycle = -1;
    rdy0 = (uart_rdy_o === 1'b1);
    if (auto_rd && stop_ok) exp_q.push_back(data);
    $display("send frame %02h stop=%0d skew=%0.3f", data, stop_ok, skew);
    for (int c = 0; c < n; c++) begin
      step_cycle();
      bp = $rtoi($itor(c) / cpb);
      if (bp == 0) rx = 1'b0;
      else if (bp <= 8) rx = data[bp-1];
      else rx = stop_ok;
      if (!rdy0 && rdy_cycle < 0 && uart_rdy_o === 1'b1) rdy_cycle = c;
      if (c == rd_cycle) begin
        checks++;
        if (uart_rdy_o !== 1'b1 || uart_dat_o !== m_dat) begin
          errors++;
          $display("FAIL pre_read_held: rdy=%b dat=%02h want rdy=1 dat=%02h", uart_rdy_o, uart_dat_o, m_dat);
        end
        rd = 1'b1;
      end
      if (rd_cycle >= 0 && c == rd_cycle + 1) begin
        checks++;
        if (uart_rdy_o !== 1'b1 || uart_dat_o !== data || uart_ovr_o !== 1'b0) begin
          errors++;
          $display("FAIL same_cycle_rd: rdy=%b dat=%02h ovr=%b want rdy=1 dat=%02h ovr=0",
                   uart_rdy_o, uart_dat_o, uart_ovr_o, data);
        end
      end
      if (c == abort_cycle) return;
    end
  endtask

  task automatic host_read();
    step_cycle();
    rd = 1'b1;
    step_cycle();
    m_read();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (uart_dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat: got %02h want 00", uart_dat_o); end
    if (uart_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", uart_rdy_o); end
    if (uart_ferr_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", uart_ferr_o); end
    if (uart_ovr_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", uart_ovr_o); end
    if (uart_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", uart_busy_o); end
    rstn = 1'b1;
    idle(20, 1'b1);
    checks += 2;
    if (uart_rdy_o !== 1'b0) begin errors++; $display("FAIL post_reset_rdy: got %b want 0", uart_rdy_o); end
    if (uart_busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", uart_busy_o); end
  endtask

  task automatic test_single();
    int rc;
    int f0;
    f0 = ferr_pulses;
    send_frame(8'hA5, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'hA5);
    checks += 5;
    if (rc < 820 || rc > 836) begin errors++; $display("FAIL single_latency: got %0d clocks want 820..836", rc); end
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL single_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL single_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (uart_ovr_o !== m_ovr) begin errors++; $display("FAIL single_ovr: got %b want %b", uart_ovr_o, m_ovr); end
    if (ferr_pulses != f0) begin errors++; $display("FAIL single_ferr: got %0d pulses want %0d", ferr_pulses, f0); end
    host_read();
    checks++;
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL single_read_clr: got rdy=%b want %b", uart_rdy_o, m_rdy); end
  endtask

  task automatic test_back_to_back();
    real skews[3];
    int  rc;
    int  f0;
    skews[0] = 0.0; skews[1] = 0.02; skews[2] = -0.02;
    auto_rd = 1'b1;
    for (int s = 0; s < 3; s++) begin
      f0 = ferr_pulses;
      send_frame(8'h00, 1'b1, skews[s], -1, -1, rc);
      send_frame(8'hFF, 1'b1, skews[s], -1, -1, rc);
      send_frame(8'h55, 1'b1, skews[s], -1, -1, rc);
      idle(60, 1'b1);
      checks += 3;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d undelivered want 0", exp_q.size()); end
      if (ferr_pulses != f0) begin errors++; $display("FAIL b2b_ferr: got %0d pulses want %0d", ferr_pulses, f0); end
      if (uart_ovr_o !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", uart_ovr_o); end
      exp_q.delete();
    end
    auto_rd = 1'b0;
  endtask

  task automatic test_glitch();
    int  f0;
    bit  seen_busy;
    int  drop_at;
    f0 = ferr_pulses;
    seen_busy = 1'b0;
    drop_at = -1;
    idle(20, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step_cycle();
      rx = 1'b1;
      if (uart_busy_o === 1'b1) seen_busy = 1'b1;
      else if (seen_busy) begin
        drop_at = 20 + i;
        break;
      end
    end
    checks += 4;
    if (!seen_busy) begin errors++; $display("FAIL glitch_busy_rise: got busy never high want high"); end
    if (drop_at < 0 || drop_at > 70) begin errors++; $display("FAIL glitch_busy_drop: got %0d clocks want <=70", drop_at); end
    if (uart_rdy_o !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", uart_rdy_o); end
    if (ferr_pulses != f0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want %0d", ferr_pulses, f0); end
    idle(100, 1'b1);
  endtask

  task automatic test_framing();
    int rc;
    int f0;
    int fc0;
    f0 = ferr_pulses;
    fc0 = ferr_cycles;
    send_frame(8'h3C, 1'b0, 0.0, -1, -1, rc);
    idle(260, 1'b0);
    checks += 4;
    if (ferr_pulses != f0 + 1) begin errors++; $display("FAIL ferr_count: got %0d want %0d", ferr_pulses - f0, 1); end
    if (ferr_cycles != fc0 + 1) begin errors++; $display("FAIL ferr_width: got %0d cycles want 1", ferr_cycles - fc0); end
    if (uart_rdy_o !== 1'b0) begin errors++; $display("FAIL ferr_no_deliver: got rdy=%b want 0", uart_rdy_o); end
    if (uart_busy_o !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b want 1", uart_busy_o); end
    idle(20, 1'b1);
    checks++;
    if (uart_busy_o !== 1'b0) begin errors++; $display("FAIL ferr_break_exit: got busy=%b want 0", uart_busy_o); end
    f0 = ferr_pulses;
    send_frame(8'h81, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h81);
    checks += 3;
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL after_ferr_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL after_ferr_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (ferr_pulses != f0) begin errors++; $display("FAIL after_ferr_ferr: got %0d pulses want %0d", ferr_pulses, f0); end
    host_read();
  endtask

  task automatic test_overrun();
    int     rc;
    int     rd_cycle;
    longint num;
    send_frame(8'h11, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h11);
    idle(10, 1'b1);
    send_frame(8'h22, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h22);
    checks += 3;
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL ovr_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL ovr_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (uart_ovr_o !== m_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b", uart_ovr_o, m_ovr); end
    host_read();
    checks += 2;
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL ovr_read_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (uart_ovr_o !== m_ovr) begin errors++; $display("FAIL ovr_read_clr: got %b want %b", uart_ovr_o, m_ovr); end
    idle(10, 1'b1);
    send_frame(8'h44, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h44);
    idle(10, 1'b1);
    // Stop sample lands on the 152nd tick after the detect edge, which is
    // the third rising edge after the line falls.
    num = 64'd152 * 64'd10000000;
    rd_cycle = 3 + int'((num + 64'd1843199) / 64'd1843200) - 1;
    send_frame(8'h33, 1'b1, 0.0, rd_cycle, -1, rc);
    m_read();
    m_deliver(8'h33);
    checks += 3;
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL simul_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL simul_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (uart_ovr_o !== m_ovr) begin errors++; $display("FAIL simul_ovr: got %b want %b", uart_ovr_o, m_ovr); end
    host_read();
  endtask

  task automatic test_reset_midframe();
    int rc;
    send_frame(8'h96, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h96);
    idle(10, 1'b1);
    send_frame(8'hC3, 1'b1, 0.0, -1, 477, rc);
    #10 rstn = 1'b0;
    #1;
    m_dat = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0;
    checks += 3;
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL arst_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL arst_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    if (uart_busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", uart_busy_o); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(200, 1'b0);
    checks++;
    if (uart_busy_o !== 1'b0) begin errors++; $display("FAIL low_after_reset: got busy=%b want 0", uart_busy_o); end
    idle(30, 1'b1);
    send_frame(8'h5A, 1'b1, 0.0, -1, -1, rc);
    m_deliver(8'h5A);
    checks += 2;
    if (uart_dat_o !== m_dat) begin errors++; $display("FAIL post_arst_dat: got %02h want %02h", uart_dat_o, m_dat); end
    if (uart_rdy_o !== m_rdy) begin errors++; $display("FAIL post_arst_rdy: got %b want %b", uart_rdy_o, m_rdy); end
    host_read();
  endtask

  task automatic test_random();
    int         rc;
    int         f0;
    logic [7:0] d;
    real        skew;
    f0 = ferr_pulses;
    auto_rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom_range(0, 255));
      skew = ($itor($urandom_range(0, 40)) - 20.0) / 1000.0;
      send_frame(d, 1'b1, skew, -1, -1, rc);
      idle($urandom_range(0, 150), 1'b1);
    end
    idle(60, 1'b1);
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending: got %0d undelivered want 0", exp_q.size()); end
    if (ferr_pulses != f0) begin errors++; $display("FAIL rand_ferr: got %0d pulses want %0d", ferr_pulses, f0); end
    if (uart_ovr_o !== 1'b0) begin errors++; $display("FAIL rand_ovr: got %b want 0", uart_ovr_o); end
    auto_rd = 1'b0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for the serial debug/data link. Its line format is the same as the on-chip UART transmitter: 8N1, LSB first, idle high, 115200 baud from a 10 MHz system clock. It oversamples the asynchronous RX line at 16x, checks framing, and presents each received byte in a holding register with a ready/read handshake toward the host logic (e.g. the AES command loader).

Parameters:
CLK_HZ, 10000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVS, 16, oversampling factor (fixed at 16; mid-bit sample at tick 8)

Ports:
sys_clk_i  input  1  system clock
sys_rstn_i  input  1  reset, asynchronous, active-low
uart_rx_i  input  1  asynchronous serial input, idle high
uart_rd_i  input  1  host read strobe; consumes the held byte
uart_dat_o  output  8  received byte, stable while uart_rdy_o=1
uart_rdy_o  output  1  level high while an unread byte is held
uart_ferr_o  output  1  one-cycle pulse on stop-bit framing error
uart_ovr_o  output  1  sticky overrun flag, cleared by uart_rd_i
uart_busy_o  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset is asynchronous, active-low; clock is sys_clk_i.
- Reset values: uart_dat_o=0, uart_rdy_o=0, uart_ferr_o=0, uart_ovr_o=0, uart_busy_o=0. Both synchronizer flops reset to 1. FSM resets to IDLE.
- Sync: uart_rx_i passes through 2 flops; all logic uses the synced value rxs.
- Tick generator: fractional accumulator that adds BAUD*OVS each cycle and subtracts CLK_HZ on overflow, producing a 1-cycle tick. This gives about 5.43 clocks per tick at the defaults. Accumulator width must hold CLK_HZ+BAUD*OVS (>=24 bits at defaults). The accumulator and tick counter are cleared on start detect to align sampling.
- FSM states:
  - IDLE: a falling edge on rxs (prev=1, now=0) goes to START and clears the tick count.
  - START: at tick count 7 (mid start bit), if rxs=0 go to DATA with bit index 0; if rxs=1 it was a glitch, so return to IDLE with no flags.
  - DATA: sample rxs every 16 ticks after the mid-start sample. Shift it into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP: sample 16 ticks after data bit 7.
    - rxs=1 is a valid frame: deliver and go to IDLE.
    - rxs=0 is a framing error: pulse uart_ferr_o for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. Continuous low is never re-detected as new starts.
- Deliver: if uart_rdy_o=0, load uart_dat_o and set uart_rdy_o the cycle after the stop sample. If uart_rdy_o=1, discard the new byte, keep uart_dat_o unchanged and set uart_ovr_o.
- uart_rd_i while uart_rdy_o=1 clears uart_rdy_o and uart_ovr_o next cycle. uart_rd_i while uart_rdy_o=0 is ignored.
- Simultaneous uart_rd_i and deliver in the same cycle: the read consumes the old byte, the new byte loads, uart_rdy_o stays 1, and no overrun is flagged.
- Latency: uart_rdy_o rises 9.5 bit times (+2 sync cycles, +/-1 tick) after the start falling edge.
- Reset mid-frame: all state returns to reset values immediately and the partial byte is lost. After reset, a line that is already low is not treated as a start until it returns high and then falls.

Test Plan:
- Single byte: send 0xA5 at 115200 (86.8 clk/bit) -> uart_rdy_o=1 with uart_dat_o=0xA5 about 825 clocks after the start edge; uart_ferr_o and uart_ovr_o stay 0; uart_rd_i pulse clears uart_rdy_o.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap, reading each byte -> three deliveries in order, no errors. Repeat with +/-2% baud skew and get the same result.
- Glitch: pulse rx low for 20 clocks -> FSM returns to IDLE, uart_rdy_o and uart_ferr_o stay 0, uart_busy_o drops within about 50 clocks.
- Framing error: send 0x3C with stop bit low, then hold low for 3 bit times -> one uart_ferr_o pulse, no delivery, no spurious start until rx is high; a following 0x81 is received correctly.
- Overrun: send 0x11 then 0x22 without reading -> uart_dat_o=0x11 and uart_ovr_o=1. Read -> both flags clear. Then send 0x33 and assert uart_rd_i in the same cycle as the deliver of a held byte -> uart_dat_o=0x33, uart_rdy_o=1, uart_ovr_o=0.
- Reset mid-frame: assert sys_rstn_i low during data bit 4 of 0xC3 -> outputs go to reset values asynchronously; after release the next full frame 0x5A is received correctly.
